id_ex_pipe_reg: RTL

- Parametrised ID/EX pipeline register between decode (stage 2) and execute (stage 3).
- Carries the WB/MEM/EX control fields, PC, both operand values, the sign-extended immediate, and the rs/rt/rd register addresses.
- Adds a valid/ready handshake, flush-to-bubble, and an optional 2-entry skid buffer so that in_ready is registered.
- Bubbles present all-zero control fields, so no register write and no memory access occur downstream.

---
 rtl/id_ex_pipe_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with a valid/ready handshake, flush-to-bubble and an optional skid buffer.
// Latency is 1 cycle. Define ID_EX_SKID_EN to add a 2-entry skid, which registers in_ready; otherwise in_ready depends on out_ready in the same cycle.
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int WB_W   = 2,
    parameter int MEM_W  = 2,
    parameter int EX_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   control_WB_s2,
    input  logic [MEM_W-1:0]  control_MEM_s2,
    input  logic [EX_W-1:0]   control_EX_s2,
    input  logic [XLEN-1:0]   pc_s2,
    input  logic [XLEN-1:0]   rs_data_s2,
    input  logic [XLEN-1:0]   rt_data_s2,
    input  logic [XLEN-1:0]   seimm_s2,
    input  logic [REG_AW-1:0] rs_addr_s2,
    input  logic [REG_AW-1:0] rt_addr_s2,
    input  logic [REG_AW-1:0] rd_addr_s2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   control_WB_s3,
    output logic [MEM_W-1:0]  control_MEM_s3,
    output logic [EX_W-1:0]   control_EX_s3,
    output logic [XLEN-1:0]   pc_s3,
    output logic [XLEN-1:0]   rs_data_s3,
    output logic [XLEN-1:0]   rt_data_s3,
    output logic [XLEN-1:0]   seimm_s3,
    output logic [REG_AW-1:0] rs_addr_s3,
    output logic [REG_AW-1:0] rt_addr_s3,
    output logic [REG_AW-1:0] rd_addr_s3,
    output logic [REG_AW-1:0] rt_addr_fw
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [MEM_W-1:0]  mem;
        logic [EX_W-1:0]   ex;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   seimm;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [REG_AW-1:0] rd_addr;
    } entry_t;

    entry_t in_ent;
    entry_t main_q, main_d;
    logic   main_vld_q, main_vld_d;
    logic   in_fire, out_fire;

    assign in_ent = '{wb: control_WB_s2, mem: control_MEM_s2, ex: control_EX_s2,
                      pc: pc_s2, rs_data: rs_data_s2, rt_data: rt_data_s2,
                      seimm: seimm_s2, rs_addr: rs_addr_s2, rt_addr: rt_addr_s2,
                      rd_addr: rd_addr_s2};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_vld_q & out_ready;

`ifdef ID_EX_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_rdy_q, in_rdy_d;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            main_d.wb  = '0;
            main_d.mem = '0;
            main_d.ex  = '0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || out_fire) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                // Bubble: controls go to zero, datapath values are left as they were.
                main_vld_d = 1'b0;
                main_d.wb  = '0;
                main_d.mem = '0;
                main_d.ex  = '0;
            end
        end else if (in_fire) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
        end
        in_rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_ready = in_rdy_q;
`else
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            main_d.wb  = '0;
            main_d.mem = '0;
            main_d.ex  = '0;
        end else if (!main_vld_q || out_fire) begin
            if (in_fire) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
                main_d.wb  = '0;
                main_d.mem = '0;
                main_d.ex  = '0;
            end
        end
    end

    assign in_ready = !main_vld_q | out_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    assign out_valid      = main_vld_q;
    assign control_WB_s3  = main_q.wb;
    assign control_MEM_s3 = main_q.mem;
    assign control_EX_s3  = main_q.ex;
    assign pc_s3          = main_q.pc;
    assign rs_data_s3     = main_q.rs_data;
    assign rt_data_s3     = main_q.rt_data;
    assign seimm_s3       = main_q.seimm;
    assign rs_addr_s3     = main_q.rs_addr;
    assign rt_addr_s3     = main_q.rt_addr;
    assign rd_addr_s3     = main_q.rd_addr;
    assign rt_addr_fw     = main_q.rt_addr;

endmodule
